// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the two-requester MIG app-interface arbiter.
package ddr_arb_pkg;

   localparam int DEF_ADDR_W = 28;
   localparam int DEF_DATA_W = 128;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RWAIT = 2'd2,
      S_DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner selection; the history bit lives in the caller.
module rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       valid_o,
   output logic       winner_o
);

   // A lone requester wins outright; on a tie the one not served last wins.
   always_comb begin
      valid_o  = |req_i;
      winner_o = (req_i == 2'b11) ? ~last_grant_i : req_i[1];
   end

endmodule

// File: rtl/ddr_app_arbiter.sv
// Round-robin arbiter/sequencer that serialises single-beat 128-bit reads and
// writes from two masters onto the MIG app_* interface, one at a time.
module ddr_app_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int MASK_W = DATA_W/8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   calib_done,
   input  logic [1:0]             req,
   input  logic [1:0]             we,
   input  logic [1:0][ADDR_W-1:0] addr,
   input  logic [1:0][DATA_W-1:0] wdata,
   output logic [1:0]             done,
   output logic [DATA_W-1:0]      rdata,
   output logic                   busy,
   output logic                   grant_id,
   output logic [ADDR_W-1:0]      app_addr,
   output logic [2:0]             app_cmd,
   output logic                   app_en,
   input  logic                   app_rdy,
   output logic [DATA_W-1:0]      app_wdf_data,
   output logic [MASK_W-1:0]      app_wdf_mask,
   output logic                   app_wdf_wren,
   output logic                   app_wdf_end,
   input  logic                   app_wdf_rdy,
   input  logic [DATA_W-1:0]      app_rd_data,
   input  logic                   app_rd_data_valid,
   input  logic                   app_rd_data_end
);

   arb_state_t         state_q, state_d;
   logic               last_grant_q, last_grant_d;
   logic               grant_id_q, grant_id_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic               cmd_ok_q, cmd_ok_d;
   logic               wdf_ok_q, wdf_ok_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;

   logic               pick_valid, pick_winner;
   logic               en_raw, wren_raw, cmd_hs, wdf_hs;

   // Single-beat transfers: the end-of-burst flag carries no information.
   logic               unused_rd_end;
   assign unused_rd_end = app_rd_data_end;

   rr_pick2 u_pick (
      .req_i        (req),
      .last_grant_i (last_grant_q),
      .valid_o      (pick_valid),
      .winner_o     (pick_winner)
   );

   // Command and write-data strobes each stay up until their own handshake.
   always_comb begin
      en_raw   = (state_q == S_ISSUE) && !cmd_ok_q;
      wren_raw = (state_q == S_ISSUE) && we_q && !wdf_ok_q;
      cmd_hs   = en_raw & app_rdy;
      wdf_hs   = wren_raw & app_wdf_rdy;
   end

   // Next-state and latch control for the transaction sequencer.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cmd_ok_d     = cmd_ok_q;
      wdf_ok_d     = wdf_ok_q;
      rdata_d      = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (calib_done && pick_valid) begin
               state_d      = S_ISSUE;
               last_grant_d = pick_winner;
               grant_id_d   = pick_winner;
               we_d         = we[pick_winner];
               addr_d       = addr[pick_winner];
               wdata_d      = wdata[pick_winner];
               cmd_ok_d     = 1'b0;
               wdf_ok_d     = 1'b0;
            end
         end
         S_ISSUE: begin
            cmd_ok_d = cmd_ok_q | cmd_hs;
            wdf_ok_d = wdf_ok_q | wdf_hs;
            if (we_q) begin
               if (cmd_ok_d && wdf_ok_d) state_d = S_DONE;
            end else if (cmd_ok_d) begin
               state_d = S_RWAIT;
            end
         end
         S_RWAIT: begin
            if (app_rd_data_valid) begin
               rdata_d = app_rd_data;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            cmd_ok_d = 1'b0;
            wdf_ok_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; last_grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         grant_id_q   <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cmd_ok_q     <= 1'b0;
         wdf_ok_q     <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cmd_ok_q     <= cmd_ok_d;
         wdf_ok_q     <= wdf_ok_d;
         rdata_q      <= rdata_d;
      end
   end

   // Output decode; reset masks every strobe in the same cycle it is raised.
   always_comb begin
      app_en       = en_raw & ~reset;
      app_wdf_wren = wren_raw & ~reset;
      app_wdf_end  = wren_raw & ~reset;
      app_cmd      = we_q ? CMD_WRITE : CMD_READ;
      app_addr     = addr_q;
      app_wdf_data = wdata_q;
      app_wdf_mask = '0;
      done         = 2'b00;
      if (state_q == S_DONE && !reset) done = grant_id_q ? 2'b10 : 2'b01;
      busy         = (state_q != S_IDLE);
      grant_id     = grant_id_q;
      rdata        = rdata_q;
   end

endmodule

// File: tb/tb_ddr_app_arbiter.sv
// Self-checking bench: a queue-driven requester pair, a small MIG memory model,
// and a reference of "reads return the last completed write" with strict
// alternation under continuous contention.
module tb_ddr_app_arbiter;
   localparam int AW = 28;
   localparam int DW = 128;
   localparam int MW = DW/8;
   localparam logic [DW-1:0] DEAD = {4{32'hDEADBEEF}};

   typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; } op_t;
   typedef struct { int cyc; int id; logic [DW-1:0] rd; logic gid; int vcyc; } done_t;
   typedef struct { int cyc; logic [2:0] cmd; logic [AW-1:0] a; } cmd_t;
   typedef struct { int due; logic [DW-1:0] d; } rd_t;

   logic clk = 1'b0;
   logic reset, calib_done;
   logic [1:0]          req = '0;
   logic [1:0]          we = '0;
   logic [1:0][AW-1:0]  addr = '0;
   logic [1:0][DW-1:0]  wdata = '0;
   logic [1:0]          done;
   logic [DW-1:0]       rdata;
   logic                busy, grant_id;
   logic [AW-1:0]       app_addr;
   logic [2:0]          app_cmd;
   logic                app_en;
   logic                app_rdy = 1'b1;
   logic [DW-1:0]       app_wdf_data;
   logic [MW-1:0]       app_wdf_mask;
   logic                app_wdf_wren, app_wdf_end;
   logic                app_wdf_rdy = 1'b1;
   logic [DW-1:0]       app_rd_data = '0;
   logic                app_rd_data_valid = 1'b0;
   logic                app_rd_data_end = 1'b0;

   ddr_app_arbiter dut (
      .clk(clk), .reset(reset), .calib_done(calib_done), .req(req), .we(we),
      .addr(addr), .wdata(wdata), .done(done), .rdata(rdata), .busy(busy),
      .grant_id(grant_id), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
      .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
      .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .app_rd_data_end(app_rd_data_end)
   );

   always #5 clk = ~clk;

   // Written by the test sequence only.
   op_t ops [2][$];
   bit  kill = 1'b0;
   int  hold_gen = 0, hold_rdy = 0, hold_wdf = 0;
   bit  rnd_rdy = 1'b0, rnd_lat = 1'b0;
   int  fix_lat = 3;
   int  n_tests = 0, n_fail = 0;

   // Written by the negedge process only.
   int    cyc = 0, rp [2] = '{0, 0}, pres_cyc [2] = '{0, 0};
   done_t done_log[$];
   op_t   done_ops[$];
   cmd_t  cmd_log[$];
   logic [DW-1:0] wd_log[$];
   int    busy_rise[$];
   int    en_cycles = 0, wren_cycles = 0, mask_bad = 0, end_bad = 0;
   bit    prev_busy = 1'b0;
   logic [DW-1:0] mem [logic [AW-1:0]];
   rd_t   rd_q[$];
   int    seen_gen = 0, rdy_cnt = 0, wdf_cnt = 0, last_vcyc = -1, lat;
   bit    pa_v = 1'b0, pd_v = 1'b0;
   logic [AW-1:0] pa;
   logic [DW-1:0] pd;

   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return {4{{4'h0, a} ^ 32'h5A5A_0000}};
   endfunction

   // Monitor, MIG memory model and the two requesters, all on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (done != 2'b00) done_log.push_back('{cyc, done[1] ? 1 : 0, rdata, grant_id, last_vcyc});
      if (busy && !prev_busy) busy_rise.push_back(cyc);
      prev_busy = busy;
      if (app_en) en_cycles++;
      if (app_wdf_wren) wren_cycles++;
      if (app_wdf_wren !== app_wdf_end) end_bad++;
      if (app_wdf_mask !== '0) mask_bad++;

      if (reset) begin pa_v = 1'b0; pd_v = 1'b0; end
      if (hold_gen != seen_gen) begin seen_gen = hold_gen; rdy_cnt = hold_rdy; wdf_cnt = hold_wdf; end
      if (rdy_cnt > 0 && app_en) begin app_rdy = 1'b0; rdy_cnt--; end
      else app_rdy = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (wdf_cnt > 0 && app_wdf_wren) begin app_wdf_rdy = 1'b0; wdf_cnt--; end
      else app_wdf_rdy = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (app_en && app_rdy) begin
         cmd_log.push_back('{cyc, app_cmd, app_addr});
         if (app_cmd == 3'b000) begin pa = app_addr; pa_v = 1'b1; end
         else begin
            lat = rnd_lat ? int'($urandom_range(1, 6)) : fix_lat;
            rd_q.push_back('{cyc + lat, mem.exists(app_addr) ? mem[app_addr] : dflt(app_addr)});
         end
      end
      if (app_wdf_wren && app_wdf_rdy) begin wd_log.push_back(app_wdf_data); pd = app_wdf_data; pd_v = 1'b1; end
      if (pa_v && pd_v) begin mem[pa] = pd; pa_v = 1'b0; pd_v = 1'b0; end
      app_rd_data_valid = 1'b0;
      if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
         app_rd_data_valid = 1'b1;
         app_rd_data = rd_q[0].d;
         last_vcyc = cyc;
         void'(rd_q.pop_front());
      end

      for (int i = 0; i < 2; i++) begin
         if (kill) begin
            req[i] = 1'b0;
            rp[i] = ops[i].size();
         end else begin
            if (req[i] && done[i]) begin
               done_ops.push_back(ops[i][rp[i]]);
               rp[i]++;
               req[i] = 1'b0;
            end
            if (!req[i] && rp[i] < ops[i].size()) begin
               we[i] = ops[i][rp[i]].w;
               addr[i] = ops[i][rp[i]].a;
               wdata[i] = ops[i][rp[i]].d;
               req[i] = 1'b1;
               pres_cyc[i] = cyc;
            end
         end
      end
   end

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk); #1;
         if (rp[0] == ops[0].size() && rp[1] == ops[1].size() && req == 2'b00 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; calib_done = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_tests++; if (done !== 2'b00) begin n_fail++; $display("FAIL reset_done got %b want 00", done); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_tests++; if ({app_en, app_wdf_wren, app_wdf_end} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got %b want 000", {app_en, app_wdf_wren, app_wdf_end}); end
      n_tests++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
      n_tests++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant_id got %b want 0", grant_id); end
      reset = 1'b0;
   endtask

   task automatic test_write;
      int b = done_log.size(), cb = cmd_log.size(), wb = wd_log.size();
      int e0 = en_cycles, w0 = wren_cycles;
      bit ok;
      @(negedge clk); #1;
      ops[0].push_back('{1'b1, 28'h100, DEAD});
      wait_idle(50, ok);
      repeat (2) @(negedge clk);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL write_timeout got busy want idle"); end
      n_tests++;
      if (done_log.size() - b != 1) begin n_fail++; $display("FAIL write_done_count got %0d want 1", done_log.size() - b); end
      else begin
         n_tests++; if (done_log[b].id != 0) begin n_fail++; $display("FAIL write_done_id got %0d want 0", done_log[b].id); end
         n_tests++; if (done_log[b].cyc != pres_cyc[0] + 2) begin n_fail++; $display("FAIL write_latency got %0d want %0d", done_log[b].cyc - pres_cyc[0], 2); end
      end
      n_tests++; if (en_cycles - e0 != 1) begin n_fail++; $display("FAIL write_en_cycles got %0d want 1", en_cycles - e0); end
      n_tests++; if (wren_cycles - w0 != 1) begin n_fail++; $display("FAIL write_wren_cycles got %0d want 1", wren_cycles - w0); end
      n_tests++;
      if (cmd_log.size() - cb != 1 || wd_log.size() - wb != 1) begin n_fail++; $display("FAIL write_handshakes got %0d/%0d want 1/1", cmd_log.size() - cb, wd_log.size() - wb); end
      else if (cmd_log[cb].cmd !== 3'b000 || cmd_log[cb].a !== 28'h100 || wd_log[wb] !== DEAD) begin
         n_fail++; $display("FAIL write_cmd got cmd=%b addr=%h data=%h want 000 100 %h", cmd_log[cb].cmd, cmd_log[cb].a, wd_log[wb], DEAD);
      end
      n_tests++; if (mask_bad != 0 || end_bad != 0) begin n_fail++; $display("FAIL write_mask_end got %0d/%0d bad cycles want 0/0", mask_bad, end_bad); end
   endtask

   task automatic test_read_after_write;
      int b = done_log.size(), cb = cmd_log.size();
      bit ok;
      fix_lat = 3;
      @(negedge clk); #1;
      ops[1].push_back('{1'b0, 28'h100, '0});
      wait_idle(50, ok);
      repeat (2) @(negedge clk);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL raw_timeout got busy want idle"); end
      n_tests++;
      if (done_log.size() - b != 1 || cmd_log.size() - cb != 1) begin
         n_fail++; $display("FAIL raw_counts got done=%0d cmd=%0d want 1 1", done_log.size() - b, cmd_log.size() - cb);
      end else begin
         n_tests++; if (done_log[b].rd !== DEAD) begin n_fail++; $display("FAIL raw_rdata got %h want %h", done_log[b].rd, DEAD); end
         n_tests++; if (done_log[b].id != 1 || done_log[b].gid !== 1'b1) begin n_fail++; $display("FAIL raw_owner got id=%0d gid=%b want 1 1", done_log[b].id, done_log[b].gid); end
         n_tests++; if (cmd_log[cb].cmd !== 3'b001 || cmd_log[cb].a !== 28'h100) begin n_fail++; $display("FAIL raw_cmd got %b %h want 001 100", cmd_log[cb].cmd, cmd_log[cb].a); end
         n_tests++; if (done_log[b].cyc != cmd_log[cb].cyc + 3 + 1) begin n_fail++; $display("FAIL raw_latency got %0d want %0d", done_log[b].cyc - cmd_log[cb].cyc, 4); end
      end
   endtask

   task automatic test_tie;
      int b = done_log.size(), rb = busy_rise.size();
      bit ok;
      @(negedge clk); #1;
      ops[0].push_back('{1'b1, 28'h300, {4{32'h3000_0000}}});
      ops[0].push_back('{1'b1, 28'h310, {4{32'h3100_0000}}});
      ops[1].push_back('{1'b1, 28'h320, {4{32'h3200_0000}}});
      ops[1].push_back('{1'b1, 28'h330, {4{32'h3300_0000}}});
      wait_idle(100, ok);
      repeat (2) @(negedge clk);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL tie_timeout got busy want idle"); end
      n_tests++;
      if (done_log.size() - b != 4 || busy_rise.size() - rb != 4) begin
         n_fail++; $display("FAIL tie_counts got done=%0d grants=%0d want 4 4", done_log.size() - b, busy_rise.size() - rb);
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_tests++; if (done_log[b+k].id != k % 2) begin n_fail++; $display("FAIL tie_order[%0d] got %0d want %0d", k, done_log[b+k].id, k % 2); end
         end
         for (int k = 1; k < 4; k++) begin
            n_tests++; if (busy_rise[rb+k] != done_log[b+k-1].cyc + 2) begin n_fail++; $display("FAIL tie_gap[%0d] got %0d want 2", k, busy_rise[rb+k] - done_log[b+k-1].cyc); end
         end
      end
   endtask

   task automatic test_backpressure;
      for (int s = 0; s < 2; s++) begin
         int b = done_log.size(), e0 = en_cycles, w0 = wren_cycles;
         int want_en = (s == 0) ? 4 : 6, want_wr = (s == 0) ? 6 : 4;
         bit ok;
         @(negedge clk); #1;
         hold_rdy = (s == 0) ? 3 : 5;
         hold_wdf = (s == 0) ? 5 : 3;
         hold_gen++;
         ops[0].push_back('{1'b1, 28'h400 + 28'(s * 16), {4{32'h4000_0000 + 32'(s)}}});
         wait_idle(60, ok);
         repeat (2) @(negedge clk);
         n_tests++; if (!ok) begin n_fail++; $display("FAIL bp%0d_timeout got busy want idle", s); end
         n_tests++; if (en_cycles - e0 != want_en) begin n_fail++; $display("FAIL bp%0d_en_cycles got %0d want %0d", s, en_cycles - e0, want_en); end
         n_tests++; if (wren_cycles - w0 != want_wr) begin n_fail++; $display("FAIL bp%0d_wren_cycles got %0d want %0d", s, wren_cycles - w0, want_wr); end
         n_tests++;
         if (done_log.size() - b != 1) begin n_fail++; $display("FAIL bp%0d_done_count got %0d want 1", s, done_log.size() - b); end
         else if (done_log[b].cyc != pres_cyc[0] + 7) begin n_fail++; $display("FAIL bp%0d_done_cycle got %0d want 7", s, done_log[b].cyc - pres_cyc[0]); end
      end
   endtask

   task automatic test_calib;
      int b = done_log.size(), rb = busy_rise.size(), e0 = en_cycles, cal_c;
      bit ok, seen = 1'b0;
      @(negedge clk); #1;
      calib_done = 1'b0;
      ops[0].push_back('{1'b1, 28'h500, {4{32'h5000_0000}}});
      repeat (20) @(negedge clk);
      n_tests++; if (busy_rise.size() != rb || busy !== 1'b0) begin n_fail++; $display("FAIL calib_gate_busy got %0d grants want 0", busy_rise.size() - rb); end
      n_tests++; if (en_cycles != e0) begin n_fail++; $display("FAIL calib_gate_en got %0d want 0", en_cycles - e0); end
      #1; cal_c = cyc; calib_done = 1'b1;
      for (int n = 0; n < 5 && !seen; n++) begin
         @(negedge clk); #1;
         if (busy) begin seen = 1'b1; calib_done = 1'b0; end
      end
      wait_idle(50, ok);
      calib_done = 1'b1;
      n_tests++;
      if (!seen || !ok || busy_rise.size() - rb != 1) begin n_fail++; $display("FAIL calib_grant got seen=%0d grants=%0d want 1 1", seen, busy_rise.size() - rb); end
      else if (busy_rise[rb] != cal_c + 1) begin n_fail++; $display("FAIL calib_grant_cycle got %0d want 1", busy_rise[rb] - cal_c); end
      n_tests++; if (done_log.size() - b != 1) begin n_fail++; $display("FAIL calib_drop_done got %0d want 1", done_log.size() - b); end
   endtask

   task automatic test_reset_mid_read;
      int b = done_log.size();
      bit in_rwait = 1'b0;
      fix_lat = 8;
      @(negedge clk); #1;
      ops[0].push_back('{1'b0, 28'h600, '0});
      for (int n = 0; n < 20 && !in_rwait; n++) begin
         @(negedge clk); #1;
         if (busy && !app_en && rp[0] < ops[0].size()) in_rwait = 1'b1;
      end
      n_tests++; if (!in_rwait) begin n_fail++; $display("FAIL rstrd_reach_rwait got 0 want 1"); end
      reset = 1'b1; kill = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0; kill = 1'b0;
      repeat (15) @(negedge clk);
      #1;
      n_tests++; if (done_log.size() != b) begin n_fail++; $display("FAIL rstrd_done got %0d pulses want 0", done_log.size() - b); end
      n_tests++; if (rdata !== '0) begin n_fail++; $display("FAIL rstrd_rdata got %h want 0", rdata); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstrd_idle got busy=%b want 0", busy); end
      fix_lat = 3;
   endtask

   task automatic test_random;
      int b, cb, wb, wk = 0;
      bit ok;
      op_t op;
      logic [DW-1:0] ref_mem [logic [AW-1:0]];
      logic [DW-1:0] exp_d;
      @(negedge clk); #1;
      reset = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0;
      rnd_rdy = 1'b1; rnd_lat = 1'b1;
      b = done_log.size(); cb = cmd_log.size(); wb = wd_log.size();
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 16; k++)
            ops[i].push_back('{1'($urandom_range(0, 1)), 28'h1000 + 28'($urandom_range(0, 7)) * 28'h10,
                               {$urandom, $urandom, $urandom, $urandom}});
      wait_idle(3000, ok);
      repeat (2) @(negedge clk);
      rnd_rdy = 1'b0; rnd_lat = 1'b0;
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rand_timeout got busy want idle"); end
      n_tests++;
      if (done_log.size() - b != 32 || done_ops.size() != done_log.size() || cmd_log.size() - cb != 32) begin
         n_fail++; $display("FAIL rand_counts got done=%0d cmd=%0d want 32 32", done_log.size() - b, cmd_log.size() - cb);
      end else begin
         for (int k = 0; k < 32; k++) begin
            op = done_ops[b+k];
            n_tests++; if (done_log[b+k].id != k % 2) begin n_fail++; $display("FAIL rand_order[%0d] got %0d want %0d", k, done_log[b+k].id, k % 2); end
            n_tests++;
            if (cmd_log[cb+k].cmd !== (op.w ? 3'b000 : 3'b001) || cmd_log[cb+k].a !== op.a) begin
               n_fail++; $display("FAIL rand_cmd[%0d] got %b %h want %b %h", k, cmd_log[cb+k].cmd, cmd_log[cb+k].a, op.w ? 3'b000 : 3'b001, op.a);
            end
            if (op.w) begin
               ref_mem[op.a] = op.d;
               n_tests++;
               if (wb + wk >= wd_log.size() || wd_log[wb+wk] !== op.d) begin n_fail++; $display("FAIL rand_wdata[%0d] data not seen or wrong want %h", k, op.d); end
               wk++;
            end else begin
               exp_d = ref_mem.exists(op.a) ? ref_mem[op.a] : dflt(op.a);
               n_tests++; if (done_log[b+k].rd !== exp_d) begin n_fail++; $display("FAIL rand_rdata[%0d] got %h want %h", k, done_log[b+k].rd, exp_d); end
               n_tests++; if (done_log[b+k].cyc != done_log[b+k].vcyc + 1) begin n_fail++; $display("FAIL rand_rd_timing[%0d] got %0d want 1", k, done_log[b+k].cyc - done_log[b+k].vcyc); end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_after_write();
      test_tie();
      test_backpressure();
      test_calib();
      test_reset_mid_read();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no finish want finish within 50000 cycles");
      $fatal(1, "watchdog");
   end

endmodule
